pipe_stall_ctrl: RTL

- Central stall/flush sequencer for the 5-stage RV32IMC pipeline.
- Drives the stall and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves load-use hazards, control-flow redirects, external memory wait, and the multi-cycle divider.
- Launches the divider and holds EX until its result is ready, so DIVout reaches the MEM/WB stage correctly.

---
 rtl/pipe_stall_ctrl_pkg.sv | 30 +++
 rtl/pipe_stall_ctrl_hazard_detect.sv | 31 +++
 rtl/pipe_stall_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
//   - psc_state_e : sequencer state encoding
//   - psc_ctrl_t  : bundle of stall/flush/divider control outputs
//   - default parameter values for divider latency, counter and register index widths
package pipe_stall_ctrl_pkg;

    localparam int unsigned PSC_DIV_LATENCY  = 34;
    localparam int unsigned PSC_CNT_W        = 6;
    localparam int unsigned PSC_REGFILE_BITS = 5;

    typedef enum logic [1:0] {
        PSC_IDLE     = 2'd0,
        PSC_DIV_RUN  = 2'd1,
        PSC_DIV_HOLD = 2'd2
    } psc_state_e;

    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_ex;
        logic stall_mem;
        logic flush_id;
        logic flush_ex;
        logic flush_mem;
        logic flush_wb;
        logic div_start;
        logic div_busy;
    } psc_ctrl_t;

endpackage

// File: rtl/pipe_stall_ctrl_hazard_detect.sv
// Load-use hazard comparator. Purely combinational.
// Ports:
//   ex_valid_i, ex_is_load_i, ex_rd_i : load instruction currently in EX
//   id_rs1_i/id_rs2_i, id_use_rs1_i/id_use_rs2_i : sources read by the ID instruction
//   load_use_o : ID consumes the load result next cycle and must wait one cycle
module pipe_stall_ctrl_hazard_detect
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int unsigned REGFILE_BITS = PSC_REGFILE_BITS
) (
    input  logic                    ex_valid_i,
    input  logic                    ex_is_load_i,
    input  logic [REGFILE_BITS-1:0] ex_rd_i,
    input  logic [REGFILE_BITS-1:0] id_rs1_i,
    input  logic [REGFILE_BITS-1:0] id_rs2_i,
    input  logic                    id_use_rs1_i,
    input  logic                    id_use_rs2_i,
    output logic                    load_use_o
);

    logic rd_nonzero;
    logic rs1_hit;
    logic rs2_hit;

    // x0 is hardwired to zero, so a load into x0 never creates a dependency.
    assign rd_nonzero = (ex_rd_i != '0);
    assign rs1_hit    = id_use_rs1_i && (id_rs1_i == ex_rd_i);
    assign rs2_hit    = id_use_rs2_i && (id_rs2_i == ex_rd_i);
    assign load_use_o = ex_valid_i && ex_is_load_i && rd_nonzero && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Resolves memory wait, control-flow redirects, multi-cycle divide and
// load-use hazards by driving the stall/flush controls of the pipeline registers.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   id_rs1/2, id_use_rs1/2   : ID-stage source operands
//   ex_valid, ex_rd, ex_is_load, ex_is_div, ex_redirect : EX-stage status
//   mem_wait                 : memory not ready, freeze the pipe
//   stall_if/id/ex/mem       : hold PC / pipeline register
//   flush_id/ex/mem/wb       : zero pipeline register on next edge
//   div_start, div_busy      : divider launch pulse and busy indication
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int unsigned DIV_LATENCY  = PSC_DIV_LATENCY,
    parameter int unsigned CNT_W        = PSC_CNT_W,
    parameter int unsigned REGFILE_BITS = PSC_REGFILE_BITS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [REGFILE_BITS-1:0] id_rs1,
    input  logic [REGFILE_BITS-1:0] id_rs2,
    input  logic                    id_use_rs1,
    input  logic                    id_use_rs2,
    input  logic                    ex_valid,
    input  logic [REGFILE_BITS-1:0] ex_rd,
    input  logic                    ex_is_load,
    input  logic                    ex_is_div,
    input  logic                    ex_redirect,
    input  logic                    mem_wait,
    output logic                    stall_if,
    output logic                    stall_id,
    output logic                    stall_ex,
    output logic                    stall_mem,
    output logic                    flush_id,
    output logic                    flush_ex,
    output logic                    flush_mem,
    output logic                    flush_wb,
    output logic                    div_start,
    output logic                    div_busy
);

    // The launch cycle itself counts as the first of DIV_LATENCY cycles and the
    // cnt==0 cycle as the last, hence the reload value of DIV_LATENCY-2.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LATENCY - 2);

    psc_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div_done_q, div_done_d;
    logic             load_use;
    logic             div_launch;
    psc_ctrl_t        ctrl;

    pipe_stall_ctrl_hazard_detect #(
        .REGFILE_BITS (REGFILE_BITS)
    ) u_hazard_detect (
        .ex_valid_i   (ex_valid),
        .ex_is_load_i (ex_is_load),
        .ex_rd_i      (ex_rd),
        .id_rs1_i     (id_rs1),
        .id_rs2_i     (id_rs2),
        .id_use_rs1_i (id_use_rs1),
        .id_use_rs2_i (id_use_rs2),
        .load_use_o   (load_use)
    );

    // In the first IDLE cycle after a divide the finished div is still in EX;
    // div_done keeps it from being launched a second time.
    assign div_launch = ex_valid && ex_is_div && !div_done_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_done_d = 1'b0;
        ctrl       = '0;

        unique case (state_q)
            PSC_IDLE: begin
                if (mem_wait) begin
                    ctrl.stall_if  = 1'b1;
                    ctrl.stall_id  = 1'b1;
                    ctrl.stall_ex  = 1'b1;
                    ctrl.stall_mem = 1'b1;
                end else if (ex_redirect) begin
                    ctrl.flush_id = 1'b1;
                    ctrl.flush_ex = 1'b1;
                end else if (div_launch) begin
                    ctrl.div_start = 1'b1;
                    ctrl.stall_if  = 1'b1;
                    ctrl.stall_id  = 1'b1;
                    ctrl.stall_ex  = 1'b1;
                    ctrl.flush_mem = 1'b1;
                    state_d        = PSC_DIV_RUN;
                    cnt_d          = CNT_LOAD;
                end else if (load_use) begin
                    ctrl.stall_if = 1'b1;
                    ctrl.stall_id = 1'b1;
                    ctrl.flush_ex = 1'b1;
                end
            end

            PSC_DIV_RUN: begin
                ctrl.div_busy  = 1'b1;
                ctrl.stall_if  = 1'b1;
                ctrl.stall_id  = 1'b1;
                ctrl.stall_ex  = 1'b1;
                ctrl.flush_mem = 1'b1;
                // The divider free-runs, so counting continues through mem_wait.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (mem_wait) begin
                    state_d = PSC_DIV_HOLD;
                end else begin
                    state_d    = PSC_IDLE;
                    div_done_d = 1'b1;
                end
            end

            PSC_DIV_HOLD: begin
                ctrl.div_busy  = 1'b1;
                ctrl.stall_if  = 1'b1;
                ctrl.stall_id  = 1'b1;
                ctrl.stall_ex  = 1'b1;
                ctrl.stall_mem = 1'b1;
                if (!mem_wait) begin
                    state_d    = PSC_IDLE;
                    div_done_d = 1'b1;
                end
            end

            default: begin
                state_d = PSC_IDLE;
                cnt_d   = '0;
            end
        endcase

        // During reset every pipeline register is cleared and nothing is held.
        if (rst) begin
            ctrl           = '0;
            ctrl.flush_id  = 1'b1;
            ctrl.flush_ex  = 1'b1;
            ctrl.flush_mem = 1'b1;
            ctrl.flush_wb  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= PSC_IDLE;
            cnt_q      <= '0;
            div_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_done_q <= div_done_d;
        end
    end

    assign stall_if  = ctrl.stall_if;
    assign stall_id  = ctrl.stall_id;
    assign stall_ex  = ctrl.stall_ex;
    assign stall_mem = ctrl.stall_mem;
    assign flush_id  = ctrl.flush_id;
    assign flush_ex  = ctrl.flush_ex;
    assign flush_mem = ctrl.flush_mem;
    assign flush_wb  = ctrl.flush_wb;
    assign div_start = ctrl.div_start;
    assign div_busy  = ctrl.div_busy;

endmodule
